// File: rtl/alu_pkg.sv
// Shared types and constants for the chunked adder/subtractor datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB so
// the caller can form signed overflow on the final slice.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  // The sum bit at the MSB is a ^ b ^ carry_in, so the carry in falls out by XOR.
  assign c_msb   = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first, with
// the inter-slice carry held in a register. Start/done handshake.
module chunked_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("chunked_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [CHUNK-1:0] s_chunk;
  logic             co, c_msb;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (a_q[int'(idx_q)*CHUNK +: CHUNK]),
    .b     (b_q[int'(idx_q)*CHUNK +: CHUNK]),
    .ci    (carry_q),
    .s     (s_chunk),
    .co    (co),
    .c_msb (c_msb)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1, so the borrow-in arrives inverted.
          a_d     = a;
          b_d     = (op_sub == OP_SUB) ? ~b : b;
          carry_d = (op_sub == OP_SUB) ? ~cin : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = s_chunk;
        carry_d = co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = co;
          ovf_d   = c_msb ^ co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: operand copies are not reset; they are always loaded by an accepted start before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
